// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the CPU port, the FPGA I/O port, the arbiter and the data memory.
// master = arbiter view; slave = environment (requesters + memory) view.
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_err;

    logic              fpga_req;
    logic              fpga_we;
    logic [ADDR_W-1:0] fpga_addr;
    logic [DATA_W-1:0] fpga_wdata;
    logic [DATA_W-1:0] fpga_rdata;
    logic              fpga_ack;
    logic              fpga_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic [1:0]        grant;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_err,
        input  fpga_req, fpga_we, fpga_addr, fpga_wdata,
        output fpga_rdata, fpga_ack, fpga_err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output grant
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_err,
        output fpga_req, fpga_we, fpga_addr, fpga_wdata,
        input  fpga_rdata, fpga_ack, fpga_err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  grant
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU and the FPGA I/O controller,
// one latched transaction at a time with a bounded wait for the memory ack.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_bus_arbiter_if.master     bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic                last_fpga_q, last_fpga_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   fpga_rdata_q, fpga_rdata_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                cpu_err_q, cpu_err_d;
    logic                fpga_ack_q, fpga_ack_d;
    logic                fpga_err_q, fpga_err_d;
    logic                pick_fpga;

    // State register and all latched transaction/response values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= 2'b00;
            last_fpga_q  <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            cpu_rdata_q  <= '0;
            fpga_rdata_q <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_err_q    <= 1'b0;
            fpga_ack_q   <= 1'b0;
            fpga_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_fpga_q  <= last_fpga_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            cpu_rdata_q  <= cpu_rdata_d;
            fpga_rdata_q <= fpga_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_err_q    <= cpu_err_d;
            fpga_ack_q   <= fpga_ack_d;
            fpga_err_q   <= fpga_err_d;
        end
    end

    // FPGA wins when alone, or when both ask and the CPU was served last.
    assign pick_fpga = bus.fpga_req & (~bus.cpu_req | ~last_fpga_q);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_fpga_d  = last_fpga_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        cpu_rdata_d  = cpu_rdata_q;
        fpga_rdata_d = fpga_rdata_q;
        cpu_ack_d    = 1'b0;
        cpu_err_d    = 1'b0;
        fpga_ack_d   = 1'b0;
        fpga_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cpu_req || bus.fpga_req) begin
                    grant_d = pick_fpga ? 2'b10 : 2'b01;
                    we_d    = pick_fpga ? bus.fpga_we    : bus.cpu_we;
                    addr_d  = pick_fpga ? bus.fpga_addr  : bus.cpu_addr;
                    wdata_d = pick_fpga ? bus.fpga_wdata : bus.cpu_wdata;
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end
            end

            S_ACCESS: begin
                if (bus.mem_ack) begin
                    if (!we_q) begin
                        if (grant_q[1]) fpga_rdata_d = bus.mem_rdata;
                        else            cpu_rdata_d  = bus.mem_rdata;
                    end
                    cpu_ack_d  = grant_q[0];
                    fpga_ack_d = grant_q[1];
                    state_d    = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cpu_ack_d  = grant_q[0];
                    cpu_err_d  = grant_q[0];
                    fpga_ack_d = grant_q[1];
                    fpga_err_d = grant_q[1];
                    state_d    = S_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RESP: begin
                last_fpga_d = grant_q[1];
                grant_d     = 2'b00;
                state_d     = S_IDLE;
            end

            default: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.mem_req    = (state_q == S_ACCESS);
    assign bus.mem_we     = (state_q == S_ACCESS) & we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.grant      = grant_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.cpu_err    = cpu_err_q;
    assign bus.fpga_rdata = fpga_rdata_q;
    assign bus.fpga_ack   = fpga_ack_q;
    assign bus.fpga_err   = fpga_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: single access, contention, round-robin, timeout,
// input stability during ACCESS and reset mid-transaction.
module tb_mem_bus_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit mem_en  = 1'b1;
    int mem_lat = 1;
    logic [DATA_W-1:0] mem_arr [256];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory model: acks mem_lat cycles after mem_req is first seen, for one cycle.
    initial begin
        int wait_cnt;
        logic [7:0] idx;
        wait_cnt = 0;
        for (int i = 0; i < 256; i++) mem_arr[i] = '0;
        mem_arr[64]  = 32'h0000_002A;
        mem_arr[240] = 32'h0000_00F0;
        mem_arr[4]   = 32'h0000_0104;
        mem_arr[50]  = 32'h0000_5A5A;
        mem_arr[60]  = 32'h0000_6060;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            idx = bus.mem_addr[7:0];
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                wait_cnt    = 0;
            end else if (bus.mem_req && mem_en) begin
                if (wait_cnt >= mem_lat) begin
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) mem_arr[idx] = bus.mem_wdata;
                    else            bus.mem_rdata = mem_arr[idx];
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int w;
        rst            = 1'b1;
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;
        bus.fpga_req   = 1'b0;
        bus.fpga_we    = 1'b0;
        bus.fpga_addr  = '0;
        bus.fpga_wdata = '0;
        step();
        step();

        // Reset state
        chk("rst_grant",   64'(bus.grant),   64'(0));
        chk("rst_mem_req", 64'(bus.mem_req), 64'(0));
        chk("rst_acks",    64'({bus.cpu_ack, bus.fpga_ack, bus.cpu_err, bus.fpga_err}), 64'(0));
        chk("rst_rdata",   64'({bus.cpu_rdata, bus.fpga_rdata}), 64'(0));

        // T1: single CPU read at 320, memory acks one cycle after mem_req
        rst          = 1'b0;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'd320;
        step();
        chk("t1_grant",    64'(bus.grant),    64'(2'b01));
        chk("t1_mem_req",  64'(bus.mem_req),  64'(1));
        chk("t1_mem_addr", 64'(bus.mem_addr), 64'(320));
        chk("t1_mem_we",   64'(bus.mem_we),   64'(0));
        step();
        chk("t1_addr_held", 64'(bus.mem_addr), 64'(320));
        chk("t1_no_ack",    64'(bus.cpu_ack),  64'(0));
        step();
        chk("t1_ack",   64'(bus.cpu_ack),   64'(1));
        chk("t1_rdata", 64'(bus.cpu_rdata), 64'(32'h2A));
        chk("t1_err",   64'(bus.cpu_err),   64'(0));
        chk("t1_fpga_quiet", 64'(bus.fpga_ack), 64'(0));
        bus.cpu_req = 1'b0;
        step();
        chk("t1_ack_once", 64'(bus.cpu_ack), 64'(0));
        chk("t1_idle",     64'(bus.grant),   64'(0));

        // T2: contention right after reset, FPGA write 220 first, then CPU reads it back
        rst = 1'b1;
        step();
        rst            = 1'b0;
        bus.fpga_req   = 1'b1;
        bus.fpga_we    = 1'b1;
        bus.fpga_addr  = 32'd220;
        bus.fpga_wdata = 32'h15;
        bus.cpu_req    = 1'b1;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = 32'd220;
        step();
        chk("t2_grant_fpga", 64'(bus.grant),     64'(2'b10));
        chk("t2_mem_we",     64'(bus.mem_we),    64'(1));
        chk("t2_mem_wdata",  64'(bus.mem_wdata), 64'(32'h15));
        chk("t2_mem_addr",   64'(bus.mem_addr),  64'(220));
        step();
        step();
        chk("t2_fpga_ack",  64'({bus.fpga_ack, bus.fpga_err, bus.cpu_ack}), 64'(3'b100));
        chk("t2_grant_rsp", 64'(bus.grant), 64'(2'b10));
        bus.fpga_req = 1'b0;
        step();
        chk("t2_grant_gap", 64'(bus.grant), 64'(2'b00));
        step();
        chk("t2_grant_cpu", 64'(bus.grant),    64'(2'b01));
        chk("t2_cpu_addr",  64'(bus.mem_addr), 64'(220));
        step();
        step();
        chk("t2_cpu_ack",   64'(bus.cpu_ack),   64'(1));
        chk("t2_cpu_rdata", 64'(bus.cpu_rdata), 64'(32'h15));
        bus.cpu_req = 1'b0;
        step();

        // T3: both held for four transactions, owners must alternate FPGA, CPU, ...
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = 32'd60;
        bus.fpga_req  = 1'b1;
        bus.fpga_we   = 1'b0;
        bus.fpga_addr = 32'd50;
        for (int i = 0; i < 4; i++) begin
            w = 0;
            do begin
                step();
                w++;
            end while (!(bus.cpu_ack || bus.fpga_ack) && w < 12);
            chk($sformatf("t3_owner%0d", i), 64'({bus.fpga_ack, bus.cpu_ack}),
                64'((i % 2 == 0) ? 2'b10 : 2'b01));
        end
        chk("t3_cpu_rdata",  64'(bus.cpu_rdata),  64'(32'h6060));
        chk("t3_fpga_rdata", 64'(bus.fpga_rdata), 64'(32'h5A5A));
        bus.cpu_req  = 1'b0;
        bus.fpga_req = 1'b0;
        step();
        step();

        // T4: memory never acks, FPGA read must time out after TIMEOUT cycles
        mem_en        = 1'b0;
        bus.fpga_req  = 1'b1;
        bus.fpga_addr = 32'd100;
        step();
        chk("t4_grant", 64'(bus.grant), 64'(2'b10));
        cnt = 0;
        while (bus.mem_req && cnt < 20) begin
            cnt++;
            step();
        end
        chk("t4_req_cycles", 64'(cnt),            64'(TIMEOUT));
        chk("t4_ack",        64'(bus.fpga_ack),   64'(1));
        chk("t4_err",        64'(bus.fpga_err),   64'(1));
        chk("t4_rdata_kept", 64'(bus.fpga_rdata), 64'(32'h5A5A));
        chk("t4_cpu_quiet",  64'(bus.cpu_ack),    64'(0));
        bus.fpga_req = 1'b0;
        mem_en       = 1'b1;
        step();
        chk("t4_ack_once", 64'(bus.fpga_ack), 64'(0));

        // T5: CPU address changes during ACCESS must not reach memory
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'd240;
        step();
        chk("t5_grant", 64'(bus.grant), 64'(2'b01));
        bus.cpu_addr = 32'd260;
        step();
        chk("t5_addr_held", 64'(bus.mem_addr), 64'(240));
        step();
        chk("t5_ack",   64'(bus.cpu_ack),   64'(1));
        chk("t5_rdata", 64'(bus.cpu_rdata), 64'(32'hF0));
        bus.cpu_req = 1'b0;
        step();

        // T6: reset in the second ACCESS cycle abandons the access; re-request completes
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'd320;
        step();
        chk("t6_grant", 64'(bus.grant), 64'(2'b01));
        step();
        rst = 1'b1;
        step();
        chk("t6_rst_mem_req", 64'(bus.mem_req),   64'(0));
        chk("t6_rst_grant",   64'(bus.grant),     64'(0));
        chk("t6_rst_no_ack",  64'(bus.cpu_ack),   64'(0));
        chk("t6_rst_rdata",   64'(bus.cpu_rdata), 64'(0));
        rst = 1'b0;
        step();
        chk("t6_regrant", 64'(bus.grant), 64'(2'b01));
        step();
        chk("t6_no_early_ack", 64'(bus.cpu_ack), 64'(0));
        step();
        chk("t6_ack",   64'(bus.cpu_ack),   64'(1));
        chk("t6_rdata", 64'(bus.cpu_rdata), 64'(32'h2A));
        chk("t6_err",   64'(bus.cpu_err),   64'(0));
        bus.cpu_req = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Arbitrates a single data-memory port between the CPU load/store path and the FPGA keypad/display I/O controller. The keypad controller writes operands and the opcode into fixed memory words and reads the result word back; the CPU reads and writes the same words. The block latches one request at a time and drives a memory transaction with a ready/ack handshake. It returns read data and a one-cycle ack to the winner, and aborts with an error flag on a memory timeout.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
TIMEOUT, 255, maximum cycles in ACCESS waiting for mem_ack before abort (must be >=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request (level)
cpu_we  in  1  CPU write enable (1 = write)
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  read data returned to CPU
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_err  out  1  timeout flag, valid only with cpu_ack
fpga_req  in  1  FPGA I/O controller request (level)
fpga_we  in  1  FPGA write enable
fpga_addr  in  ADDR_W  FPGA address
fpga_wdata  in  DATA_W  FPGA write data
fpga_rdata  out  DATA_W  read data returned to FPGA controller
fpga_ack  out  1  one-cycle completion pulse to FPGA controller
fpga_err  out  1  timeout flag, valid only with fpga_ack
mem_req  out  1  memory request, held until mem_ack or timeout
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completion
grant  out  2  one-hot owner: bit0 = CPU, bit1 = FPGA; 0 in IDLE

Behaviour:
- Reset (rst high at a clk edge): state IDLE; all outputs 0; timeout counter 0; last_served = CPU, so the FPGA wins the first contested grant.
- States: IDLE, ACCESS, RESP. All outputs are registered or decoded from state plus latched registers. No combinational path from the *_req inputs to any output.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requesting: grant the port that is not last_served (round-robin).
  - On a grant: latch we/addr/wdata from the winner, set grant, clear the counter, go to ACCESS.
- ACCESS:
  - mem_req=1; mem_we/mem_addr/mem_wdata come from the latched values and are stable for the whole state.
  - Requester inputs that change after the grant are ignored.
  - mem_ack=1: if the access is a read, capture mem_rdata into the owner's rdata register (write leaves rdata unchanged); err=0; go to RESP.
  - No mem_ack: increment the counter. When the counter reaches TIMEOUT-1 without an ack, go to RESP with err=1 and leave rdata unchanged.
- RESP:
  - Pulse the owner's ack for exactly one cycle; the owner's err reflects the timeout result.
  - Set last_served = owner, clear grant, return to IDLE.
- Latency: a request sampled in IDLE at edge N raises mem_req after N. If mem_ack arrives k cycles after mem_req rises, the ack is high during cycle N+2+k. Minimum request-to-ack latency is 2 cycles. Exactly one memory transaction per ack.
- *_rdata holds its value until the next completed read for that port.
- A requester drops req in the cycle after its ack. A req still high is a new request, arbitrated in the next IDLE cycle.
- A req dropped before the grant causes no access and no ack.
- mem_ack is ignored outside ACCESS.
- The counter is $clog2(TIMEOUT+1) bits wide and saturates; it never wraps.
- Reset mid-ACCESS or mid-RESP: mem_req and any pending ack drop at that edge. The transaction is abandoned, no ack is issued, and the requester must re-request.

Test Plan:
- Reset, then cpu_req=1, cpu_we=0, addr=320; memory acks with rdata=0x2A one cycle after mem_req -> grant=01; mem_addr=320 held; cpu_ack pulse 3 cycles after req; cpu_rdata=0x2A; cpu_err=0.
- Right after reset, cpu_req and fpga_req high in the same cycle (fpga write addr=220, data=0x15) -> FPGA served first. The CPU is served next without an idle gap beyond one IDLE cycle. Grant sequence is 10, 00, 01.
- Both requests held continuously for 4 transactions -> grants alternate FPGA, CPU, FPGA, CPU, and neither port is starved.
- With TIMEOUT=4 and mem_ack never asserted -> mem_req high 4 cycles then drops; fpga_ack=1 with fpga_err=1; fpga_rdata unchanged.
- CPU changes cpu_addr from 240 to 260 while in ACCESS -> mem_addr stays 240; the single ack reports the 240 access.
- rst asserted in the second ACCESS cycle -> next cycle mem_req=0, grant=0, no ack; a new request then completes normally.
